// File: rtl/draw_rect_pkg.sv
// draw_rect_pkg: state encoding, screen defaults and width helper shared by the draw blocks
package draw_rect_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_COLOUR_W = 18;
  localparam int DEF_DIM_W = 8;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  function automatic int max_w(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/draw_rect_scan.sv
// draw_rect_scan: raster col/row counters with look-ahead pixel index, last-pixel and interior flags
module draw_rect_scan #(
  parameter int DIM_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [DIM_W-1:0] pix_col,
  output logic [DIM_W-1:0] pix_row,
  output logic             last,
  output logic             interior
);
  logic [DIM_W-1:0] col, row, wm1, hm1;
  logic col_end;
  assign wm1 = w - DIM_W'(1);
  assign hm1 = h - DIM_W'(1);
  assign col_end = col == wm1;
  assign last = col_end && row == hm1;
  // pix_* is the index the output registers load this cycle: current when held, next when advancing
  assign pix_col = adv ? (col_end ? '0 : col + DIM_W'(1)) : col;
  assign pix_row = adv ? (col_end ? row + DIM_W'(1) : row) : row;
  assign interior = pix_col != '0 && pix_col != wm1 && pix_row != '0 && pix_row != hm1;
  always_ff @(posedge clock) begin
    if (!resetn || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= pix_col;
      row <= pix_row;
    end
  end
endmodule

// File: rtl/draw_rect.sv
// draw_rect: WxH rectangle rasteriser streaming clipped pixel writes with back-pressure.
// Define DRAW_RECT_OUTLINE_EN to honour the outline (border-only) request.
module draw_rect
  import draw_rect_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int DIM_W    = DEF_DIM_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [DIM_W-1:0]    w,
  input  logic [DIM_W-1:0]    h,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                outline,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_write,
  input  logic                vga_ready
);
  localparam int SX_W = max_w(X_W, DIM_W) + 1;
  localparam int SY_W = max_w(Y_W, DIM_W) + 1;
`ifdef DRAW_RECT_OUTLINE_EN
  localparam bit OUTLINE_EN = 1'b1;
`else
  localparam bit OUTLINE_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [DIM_W-1:0] w_q, h_q, pix_col, pix_row;
  logic [COLOUR_W-1:0] colour_q;
  logic outline_q, last, interior, accept, step, adv, load_px, suppress;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  assign accept = state == IDLE && start;
  assign step = state == DRAW && (!vga_write || vga_ready);
  assign adv = step && !last;
  assign load_px = adv || (state == LOAD && w_q != '0 && h_q != '0);
  assign sx = SX_W'(x_q) + SX_W'(pix_col);
  assign sy = SY_W'(y_q) + SY_W'(pix_row);
  assign suppress = (OUTLINE_EN && outline_q && interior) || sx >= SX_W'(SCREEN_W) || sy >= SY_W'(SCREEN_H);
  assign busy = state != IDLE;
  assign done = state == DONE;
  draw_rect_scan #(.DIM_W(DIM_W)) scan (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (accept),
    .adv      (adv),
    .w        (w_q),
    .h        (h_q),
    .pix_col  (pix_col),
    .pix_row  (pix_row),
    .last     (last),
    .interior (interior)
  );
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = (w_q == '0 || h_q == '0) ? DONE : DRAW;
      DRAW:    state_n = (step && last) ? DONE : DRAW;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      colour_q   <= '0;
      outline_q  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
    end else begin
      if (accept) begin
        x_q       <= x;
        y_q       <= y;
        w_q       <= w;
        h_q       <= h;
        colour_q  <= colour;
        outline_q <= outline;
      end
      // pixel registers hold while the sink stalls; the final accepted pixel drops the write
      if (load_px) begin
        vga_x      <= sx[X_W-1:0];
        vga_y      <= sy[Y_W-1:0];
        vga_colour <= colour_q;
        vga_write  <= !suppress;
      end else if (step) begin
        vga_write  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_draw_rect.sv
// tb_draw_rect: directed self-checking bench for draw_rect (fill, empty, clip, stall, reset, outline)
module tb_draw_rect;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, outline = 1'b0, vga_ready = 1'b1;
  logic [7:0] x = '0, w = '0, h = '0;
  logic [6:0] y = '0;
  logic [17:0] colour = '0;
  logic busy, done, vga_write;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [17:0] vga_colour;
  int checks = 0, fails = 0, cyc;
  logic seen;
  logic [14:0] got_q[$], exp_q[$];

  always #5 clock = ~clock;

  draw_rect dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .x          (x),
    .y          (y),
    .w          (w),
    .h          (h),
    .colour     (colour),
    .outline    (outline),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write),
    .vga_ready  (vga_ready)
  );

  always @(negedge clock) if (resetn && vga_write && vga_ready) got_q.push_back({vga_x, vga_y});

  function automatic logic [14:0] pk(input int a, input int b);
    return {a[7:0], b[6:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int px, input int py, input int pw, input int ph, input logic [17:0] c, input logic o);
    x = 8'(px); y = 7'(py); w = 8'(pw); h = 8'(ph); colour = c; outline = o; start = 1'b1;
    got_q.delete();
    exp_q.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 300) begin
      tick();
      c++;
    end
  endtask

  task automatic cmp_pix(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {vga_write, vga_x, vga_y, vga_colour}, 0);
    resetn = 1'b1;
    tick();

    launch(10, 20, 3, 2, 18'h3FFFF, 1'b0);
    chk("t1_busy_load", busy, 1);
    chk("t1_nowrite_load", vga_write, 0);
    tick();
    chk("t1_first_px", {vga_write, vga_x, vga_y}, {1'b1, 8'd10, 7'd20});
    chk("t1_colour", vga_colour, 18'h3FFFF);
    wait_done(2, cyc);
    chk("t1_done_at", cyc, 8);
    for (int i = 0; i < 6; i++) exp_q.push_back(pk(10 + i % 3, 20 + i / 3));
    cmp_pix("t1_px");
    tick();
    chk("t1_idle", {busy, done}, 0);

    launch(10, 20, 0, 5, 18'h1, 1'b0);
    wait_done(1, cyc);
    chk("t2_done_at", cyc, 2);
    tick();
    chk("t2_busy_low", busy, 0);
    cmp_pix("t2_px");

    launch(158, 119, 4, 2, 18'h2, 1'b0);
    wait_done(1, cyc);
    chk("t3_done_at", cyc, 10);
    exp_q.push_back(pk(158, 119));
    exp_q.push_back(pk(159, 119));
    cmp_pix("t3_px");
    tick();

    launch(10, 20, 2, 2, 18'h155, 1'b0);
    tick();
    chk("t4_px0", {vga_write, vga_x, vga_y}, {1'b1, 8'd10, 7'd20});
    tick();
    chk("t4_px1", {vga_write, vga_x, vga_y}, {1'b1, 8'd11, 7'd20});
    vga_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t4_hold", {vga_write, vga_x, vga_y}, {1'b1, 8'd11, 7'd20});
    end
    vga_ready = 1'b1;
    wait_done(6, cyc);
    chk("t4_done_at", cyc, 9);
    exp_q.push_back(pk(10, 20));
    exp_q.push_back(pk(11, 20));
    exp_q.push_back(pk(10, 21));
    exp_q.push_back(pk(11, 21));
    cmp_pix("t4_px");
    tick();

    launch(0, 0, 8, 8, 18'h5, 1'b0);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    chk("t5_rst_state", {busy, done}, 0);
    chk("t5_rst_out", {vga_write, vga_x, vga_y, vga_colour}, 0);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | done | busy;
    end
    chk("t5_no_done", seen, 0);
    launch(5, 6, 2, 1, 18'h7, 1'b0);
    wait_done(1, cyc);
    chk("t5_done_at", cyc, 4);
    exp_q.push_back(pk(5, 6));
    exp_q.push_back(pk(6, 6));
    cmp_pix("t5_px");
    tick();

    launch(0, 0, 3, 3, 18'h2A, 1'b1);
    tick();
    x = 8'd50; w = 8'd1; h = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, cyc);
    chk("t6_done_at", cyc, 11);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
`ifdef DRAW_RECT_OUTLINE_EN
        if (!(r == 1 && c == 1)) exp_q.push_back(pk(c, r));
`else
        exp_q.push_back(pk(c, r));
`endif
    cmp_pix("t6_px");
    tick();
    chk("t6_idle", busy, 0);
    tick();
    chk("t6_start_ignored", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
